// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage RV32 pipeline.
//
// Selects forwarded operands, evaluates the single-cycle ALU, runs an
// iterative shift-add multiplier for MUL/MULHU, resolves conditional
// branches, and registers everything into the EX/MEM pipeline register.
//
// Ports
//   clk, rst               clock (rising edge), synchronous active-high reset
//   id_ex_*                ID/EX register contents (operands, imm, control)
//   forwardA, forwardB     operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB,
//                          11 behaves as 00
//   mem_wb_fwd_data        MEM/WB writeback value used for forwarding
//   mem_stall              MEM cannot accept: hold EX/MEM and the multiplier
//   flush                  squash the instruction in EX (aborts a multiply)
//   ex_busy                combinational; upstream holds IF/ID and ID/EX
//   ex_mem_*               registered EX/MEM contents
// ---------------------------------------------------------------------------
module ex_stage #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_ex_valid,
    input  logic [31:0] id_ex_pc,
    input  logic [31:0] id_ex_rs1_data,
    input  logic [31:0] id_ex_rs2_data,
    input  logic [31:0] id_ex_imm,
    input  logic        id_ex_alu_src,
    input  logic [3:0]  id_ex_alu_op,
    input  logic        id_ex_branch,
    input  logic [2:0]  id_ex_funct3,
    input  logic [4:0]  id_ex_rd,
    input  logic        id_ex_reg_write,
    input  logic        id_ex_mem_read,
    input  logic        id_ex_mem_write,
    input  logic        id_ex_mem_to_reg,
    input  logic [1:0]  forwardA,
    input  logic [1:0]  forwardB,
    input  logic [31:0] mem_wb_fwd_data,
    input  logic        mem_stall,
    input  logic        flush,
    output logic        ex_busy,
    output logic        ex_mem_valid,
    output logic        ex_mem_reg_write,
    output logic        ex_mem_mem_read,
    output logic        ex_mem_mem_write,
    output logic        ex_mem_mem_to_reg,
    output logic [31:0] ex_mem_alu_result,
    output logic [31:0] ex_mem_store_data,
    output logic [4:0]  ex_mem_rd,
    output logic        ex_mem_branch_taken,
    output logic [31:0] ex_mem_branch_target
);

    // Multiplier bits retired per RUN cycle.
    localparam int SLICE = 32 / MUL_CYCLES;
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_SRL   = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLT   = 4'b1000;
    localparam logic [3:0] OP_SLTU  = 4'b1001;
    localparam logic [3:0] OP_MUL   = 4'b1010;
    localparam logic [3:0] OP_MULHU = 4'b1011;
    localparam logic [3:0] OP_PASSB = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } mul_state_t;

    mul_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       acc_q, acc_d;
    logic [63:0]       mcand_q, mcand_d;
    logic [31:0]       mplier_q, mplier_d;

    logic        valid_q, valid_d;
    logic        reg_write_q, reg_write_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        mem_to_reg_q, mem_to_reg_d;
    logic [31:0] result_q, result_d;
    logic [31:0] store_q, store_d;
    logic [4:0]  rd_q, rd_d;
    logic        taken_q, taken_d;
    logic [31:0] target_q, target_d;

    logic signed [31:0] opa, fwdb, opb;
    logic [4:0]         shamt;
    logic [31:0]        alu_res;
    logic               is_mul;
    logic               br_cond;
    logic [63:0]        partial;

    // Operand selection; 11 on either select falls back to the regfile.
    always_comb begin
        case (forwardA)
            2'b01:   opa = ex_mem_alu_result;
            2'b10:   opa = mem_wb_fwd_data;
            default: opa = id_ex_rs1_data;
        endcase
        case (forwardB)
            2'b01:   fwdb = ex_mem_alu_result;
            2'b10:   fwdb = mem_wb_fwd_data;
            default: fwdb = id_ex_rs2_data;
        endcase
        opb = id_ex_alu_src ? id_ex_imm : fwdb;
    end

    assign shamt  = opb[4:0];
    assign is_mul = (id_ex_alu_op == OP_MUL) || (id_ex_alu_op == OP_MULHU);

    // Single-cycle ALU. Multiply results are only meaningful in DONE,
    // which is the only state in which a mul-op is actually captured.
    always_comb begin
        alu_res = 32'd0;
        case (id_ex_alu_op)
            OP_ADD:   alu_res = opa + opb;
            OP_SUB:   alu_res = opa - opb;
            OP_AND:   alu_res = opa & opb;
            OP_OR:    alu_res = opa | opb;
            OP_XOR:   alu_res = opa ^ opb;
            OP_SLL:   alu_res = opa << shamt;
            OP_SRL:   alu_res = $unsigned(opa) >> shamt;
            OP_SRA:   alu_res = opa >>> shamt;
            OP_SLT:   alu_res = {31'd0, (opa < opb)};
            OP_SLTU:  alu_res = {31'd0, ($unsigned(opa) < $unsigned(opb))};
            OP_PASSB: alu_res = opb;
            OP_MUL:   alu_res = (state_q == S_DONE) ? acc_q[31:0]  : 32'd0;
            OP_MULHU: alu_res = (state_q == S_DONE) ? acc_q[63:32] : 32'd0;
            default:  alu_res = 32'd0;
        endcase
    end

    // Branch condition always compares against forwarded rs2, never imm.
    always_comb begin
        br_cond = 1'b0;
        case (id_ex_funct3)
            3'b000:  br_cond = (opa == fwdb);
            3'b001:  br_cond = (opa != fwdb);
            3'b100:  br_cond = (opa <  fwdb);
            3'b101:  br_cond = (opa >= fwdb);
            3'b110:  br_cond = ($unsigned(opa) <  $unsigned(fwdb));
            3'b111:  br_cond = ($unsigned(opa) >= $unsigned(fwdb));
            default: br_cond = 1'b0;
        endcase
    end

    // Partial product for the low SLICE bits of the remaining multiplier.
    // The multiplicand is pre-shifted so the slice lands at its weight.
    always_comb begin
        partial = 64'd0;
        for (int k = 0; k < SLICE; k++) begin
            if (mplier_q[k]) begin
                partial = partial + (mcand_q << k);
            end
        end
    end

    // DONE deliberately drops busy so the product is captured and the
    // upstream stages advance on the same edge.
    assign ex_busy = ((state_q == S_IDLE) && id_ex_valid && is_mul && !flush)
                   || (state_q == S_RUN);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        result_d     = result_q;
        store_d      = store_q;
        rd_d         = rd_q;
        taken_d      = taken_q;
        target_d     = target_q;

        if (flush) begin
            state_d      = S_IDLE;
            valid_d      = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
            result_d     = 32'd0;
            store_d      = 32'd0;
            rd_d         = 5'd0;
            taken_d      = 1'b0;
            target_d     = 32'd0;
        end else if (!mem_stall) begin
            case (state_q)
                S_IDLE: begin
                    // Operands are latched once; forward sources may move
                    // while the multiply is in flight.
                    if (id_ex_valid && is_mul) begin
                        state_d  = S_RUN;
                        cnt_d    = '0;
                        acc_d    = 64'd0;
                        mcand_d  = {32'd0, opa};
                        mplier_d = opb;
                    end
                end
                S_RUN: begin
                    acc_d    = acc_q + partial;
                    mcand_d  = mcand_q << SLICE;
                    mplier_d = mplier_q >> SLICE;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (ex_busy) begin
                valid_d      = 1'b0;
                reg_write_d  = 1'b0;
                mem_read_d   = 1'b0;
                mem_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                result_d     = 32'd0;
                store_d      = 32'd0;
                rd_d         = 5'd0;
                taken_d      = 1'b0;
                target_d     = 32'd0;
            end else begin
                valid_d      = id_ex_valid;
                reg_write_d  = id_ex_valid & id_ex_reg_write;
                mem_read_d   = id_ex_valid & id_ex_mem_read;
                mem_write_d  = id_ex_valid & id_ex_mem_write;
                mem_to_reg_d = id_ex_valid & id_ex_mem_to_reg;
                result_d     = alu_res;
                store_d      = fwdb;
                rd_d         = id_ex_rd;
                taken_d      = id_ex_branch & id_ex_valid & br_cond;
                target_d     = id_ex_pc + id_ex_imm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            acc_q        <= 64'd0;
            mcand_q      <= 64'd0;
            mplier_q     <= 32'd0;
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            result_q     <= 32'd0;
            store_q      <= 32'd0;
            rd_q         <= 5'd0;
            taken_q      <= 1'b0;
            target_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            result_q     <= result_d;
            store_q      <= store_d;
            rd_q         <= rd_d;
            taken_q      <= taken_d;
            target_q     <= target_d;
        end
    end

    assign ex_mem_valid         = valid_q;
    assign ex_mem_reg_write     = reg_write_q;
    assign ex_mem_mem_read      = mem_read_q;
    assign ex_mem_mem_write     = mem_write_q;
    assign ex_mem_mem_to_reg    = mem_to_reg_q;
    assign ex_mem_alu_result    = result_q;
    assign ex_mem_store_data    = store_q;
    assign ex_mem_rd            = rd_q;
    assign ex_mem_branch_taken  = taken_q;
    assign ex_mem_branch_target = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage (MUL_CYCLES = 4).
// Directed steps for forwarding, branches, multiply timing, stall, flush and
// reset, followed by a randomized single-cycle stream scored against a
// behavioural model of the EX/MEM register.
// ---------------------------------------------------------------------------
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_ex_valid;
    logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic        id_ex_alu_src;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_branch;
    logic [2:0]  id_ex_funct3;
    logic [4:0]  id_ex_rd;
    logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg;
    logic [1:0]  forwardA, forwardB;
    logic [31:0] mem_wb_fwd_data;
    logic        mem_stall, flush;
    logic        ex_busy;
    logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read;
    logic        ex_mem_mem_write, ex_mem_mem_to_reg;
    logic [31:0] ex_mem_alu_result, ex_mem_store_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_branch_taken;
    logic [31:0] ex_mem_branch_target;

    int n_chk  = 0;
    int n_fail = 0;

    ex_stage #(.MUL_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc),
        .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
        .id_ex_imm(id_ex_imm), .id_ex_alu_src(id_ex_alu_src),
        .id_ex_alu_op(id_ex_alu_op), .id_ex_branch(id_ex_branch),
        .id_ex_funct3(id_ex_funct3), .id_ex_rd(id_ex_rd),
        .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
        .forwardA(forwardA), .forwardB(forwardB),
        .mem_wb_fwd_data(mem_wb_fwd_data), .mem_stall(mem_stall), .flush(flush),
        .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .ex_mem_mem_write(ex_mem_mem_write), .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_store_data(ex_mem_store_data),
        .ex_mem_rd(ex_mem_rd), .ex_mem_branch_taken(ex_mem_branch_taken),
        .ex_mem_branch_target(ex_mem_branch_target)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        id_ex_valid = 0; id_ex_pc = 0; id_ex_rs1_data = 0; id_ex_rs2_data = 0;
        id_ex_imm = 0; id_ex_alu_src = 0; id_ex_alu_op = 0; id_ex_branch = 0;
        id_ex_funct3 = 0; id_ex_rd = 0; id_ex_reg_write = 0; id_ex_mem_read = 0;
        id_ex_mem_write = 0; id_ex_mem_to_reg = 0; forwardA = 0; forwardB = 0;
        mem_wb_fwd_data = 0; mem_stall = 0; flush = 0;
    endtask

    // Reference ALU: straight from the opcode table, multiply as a 64-bit product.
    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        int sa, sb;
        p  = {32'd0, a} * {32'd0, b};
        sa = a;
        sb = b;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << b[4:0];
            4'd6:  return a >> b[4:0];
            4'd7:  return 32'(sa >>> b[4:0]);
            4'd8:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  return (a < b) ? 32'd1 : 32'd0;
            4'd10: return p[31:0];
            4'd11: return p[63:32];
            4'd12: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_br(input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] m_pick(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] em, input logic [31:0] wb);
        if (sel == 2'b01) return em;
        if (sel == 2'b10) return wb;
        return rf;
    endfunction

    // One multiply from issue to capture. L stall cycles are inserted
    // starting at the second RUN cycle; with wbsrc the multiplicand comes
    // from MEM/WB and that source is scrambled after the multiply starts.
    task automatic do_mul(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int L, input bit wbsrc);
        logic [31:0] exp;
        exp = m_alu(op, a, b);
        clear_in();
        id_ex_valid = 1; id_ex_alu_op = op; id_ex_rd = 5'd9; id_ex_reg_write = 1;
        id_ex_rs2_data = b;
        if (wbsrc) begin
            forwardA = 2'b10; mem_wb_fwd_data = a; id_ex_rs1_data = 32'h5a5a_0001;
        end else begin
            id_ex_rs1_data = a;
        end
        for (int c = 0; c <= 5 + L; c++) begin
            mem_stall = (c >= 2 && c < 2 + L);
            #1;
            chk({tag, " busy"}, {63'd0, ex_busy}, {63'd0, (c < 5 + L)});
            tick();
            if (c < 5 + L) begin
                chk({tag, " bubble"}, {63'd0, ex_mem_valid}, 64'd0);
            end else begin
                chk({tag, " valid"}, {63'd0, ex_mem_valid}, 64'd1);
                chk({tag, " regwr"}, {63'd0, ex_mem_reg_write}, 64'd1);
                chk({tag, " result"}, {32'd0, ex_mem_alu_result}, {32'd0, exp});
            end
            if (c == 0 && wbsrc) mem_wb_fwd_data = $urandom;
        end
        clear_in();
    endtask

    // Behavioural EX/MEM state for the random stream.
    logic        e_valid, e_rw, e_mr, e_mw, e_m2r, e_tk, e_known;
    logic [31:0] e_res, e_st, e_tgt;
    logic [4:0]  e_rd;

    initial begin
        clear_in();
        rst = 1;
        tick(); tick();
        #1;
        chk("reset busy", {63'd0, ex_busy}, 64'd0);
        chk("reset valid", {63'd0, ex_mem_valid}, 64'd0);
        chk("reset result", {32'd0, ex_mem_alu_result}, 64'd0);
        chk("reset ctl", {59'd0, ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write,
                          ex_mem_mem_to_reg, ex_mem_branch_taken}, 64'd0);
        rst = 0;

        // Seed EX/MEM with 0x10, then forward it into an ADD.
        id_ex_valid = 1; id_ex_alu_op = 4'b1100; id_ex_alu_src = 1; id_ex_imm = 32'h10;
        id_ex_reg_write = 1;
        tick();
        chk("passb", {32'd0, ex_mem_alu_result}, 64'h10);
        clear_in();
        id_ex_valid = 1; id_ex_alu_op = 4'b0000; forwardA = 2'b01;
        id_ex_rs1_data = 32'hdead; id_ex_rs2_data = 32'h5; id_ex_rd = 5'd3;
        id_ex_reg_write = 1;
        tick();
        chk("fwdA add", {32'd0, ex_mem_alu_result}, 64'h15);
        chk("fwdA valid", {63'd0, ex_mem_valid}, 64'd1);
        chk("fwdA rd", {59'd0, ex_mem_rd}, 64'd3);

        clear_in();
        id_ex_valid = 1; id_ex_alu_op = 4'b0001; forwardB = 2'b10;
        mem_wb_fwd_data = 32'h3; id_ex_rs1_data = 32'h1; id_ex_rs2_data = 32'h77;
        id_ex_mem_write = 1;
        tick();
        chk("fwdB sub", {32'd0, ex_mem_alu_result}, 64'hFFFF_FFFE);
        chk("fwdB store", {32'd0, ex_mem_store_data}, 64'h3);
        chk("fwdB memwr", {63'd0, ex_mem_mem_write}, 64'd1);
        forwardA = 2'b11; forwardB = 2'b11; id_ex_rs1_data = 32'h7; id_ex_rs2_data = 32'h2;
        tick();
        chk("fwd11 sub", {32'd0, ex_mem_alu_result}, 64'h5);

        clear_in();
        id_ex_valid = 1; id_ex_branch = 1; id_ex_funct3 = 3'b100; id_ex_alu_src = 1;
        id_ex_rs1_data = 32'hFFFF_FFFF; id_ex_rs2_data = 32'h1;
        id_ex_pc = 32'h100; id_ex_imm = 32'h20;
        tick();
        chk("blt taken", {63'd0, ex_mem_branch_taken}, 64'd1);
        chk("blt target", {32'd0, ex_mem_branch_target}, 64'h120);
        id_ex_funct3 = 3'b110;
        tick();
        chk("bltu taken", {63'd0, ex_mem_branch_taken}, 64'd0);
        id_ex_valid = 0; id_ex_funct3 = 3'b100;
        tick();
        chk("blt invalid", {63'd0, ex_mem_branch_taken}, 64'd0);

        // Flush of an ordinary instruction leaves a zero bubble.
        clear_in();
        id_ex_valid = 1; id_ex_rs1_data = 32'h9; id_ex_reg_write = 1; id_ex_mem_read = 1;
        flush = 1;
        tick();
        chk("flush valid", {63'd0, ex_mem_valid}, 64'd0);
        chk("flush ctl", {62'd0, ex_mem_reg_write, ex_mem_mem_read}, 64'd0);
        chk("flush data", {32'd0, ex_mem_alu_result}, 64'd0);

        do_mul("mul", 4'b1010, 32'hFFFF_FFFF, 32'h2, 0, 0);
        do_mul("mulhu", 4'b1011, 32'hFFFF_FFFF, 32'h2, 0, 0);
        do_mul("mul stall", 4'b1010, 32'hFFFF_FFFF, 32'h2, 3, 0);
        for (int i = 0; i < 4; i++) begin
            do_mul("mul rnd", (i[0] ? 4'b1011 : 4'b1010), $urandom, $urandom,
                   (i == 2) ? 2 : 0, i[1]);
        end

        // Flush in RUN: abort, then a fresh multiply must take full length.
        clear_in();
        id_ex_valid = 1; id_ex_alu_op = 4'b1010; id_ex_rs1_data = 32'h3;
        id_ex_rs2_data = 32'h4; id_ex_reg_write = 1;
        tick(); tick();
        flush = 1;
        tick();
        chk("mflush valid", {63'd0, ex_mem_valid}, 64'd0);
        flush = 0; id_ex_valid = 0;
        #1;
        chk("mflush busy", {63'd0, ex_busy}, 64'd0);
        do_mul("post flush", 4'b1010, 32'h1234_5678, 32'h9abc_def1, 0, 0);

        // Reset in RUN.
        clear_in();
        id_ex_valid = 1; id_ex_alu_op = 4'b1011; id_ex_rs1_data = 32'hFFFF_0000;
        id_ex_rs2_data = 32'hFFFF_0000;
        tick(); tick(); tick();
        rst = 1; id_ex_valid = 0;
        tick();
        chk("mrst busy", {63'd0, ex_busy}, 64'd0);
        chk("mrst valid", {63'd0, ex_mem_valid}, 64'd0);
        chk("mrst result", {32'd0, ex_mem_alu_result}, 64'd0);
        chk("mrst target", {32'd0, ex_mem_branch_target}, 64'd0);
        rst = 0;
        do_mul("post rst", 4'b1011, 32'hFFFF_0000, 32'hFFFF_0000, 0, 0);

        // Random single-cycle stream against the EX/MEM model.
        rst = 1;
        tick();
        rst = 0;
        e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_tk = 0;
        e_res = 0; e_st = 0; e_tgt = 0; e_rd = 0; e_known = 1;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] a, fb, b;
            clear_in();
            id_ex_valid = ($urandom_range(0, 5) != 0);
            id_ex_alu_op = 4'($urandom_range(0, 15));
            if (id_ex_alu_op == 4'd10 || id_ex_alu_op == 4'd11) id_ex_alu_op = 4'd0;
            id_ex_pc = $urandom; id_ex_imm = $urandom;
            id_ex_rs1_data = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            id_ex_rs2_data = ($urandom_range(0, 3) == 0) ? id_ex_rs1_data : $urandom;
            id_ex_alu_src = 1'($urandom); id_ex_branch = 1'($urandom);
            id_ex_funct3 = 3'($urandom); id_ex_rd = 5'($urandom);
            id_ex_reg_write = 1'($urandom); id_ex_mem_read = 1'($urandom);
            id_ex_mem_write = 1'($urandom); id_ex_mem_to_reg = 1'($urandom);
            forwardA = 2'($urandom); forwardB = 2'($urandom);
            if (!e_known && forwardA == 2'b01) forwardA = 2'b00;
            if (!e_known && forwardB == 2'b01) forwardB = 2'b00;
            mem_wb_fwd_data = $urandom;
            flush = ($urandom_range(0, 9) == 0);
            mem_stall = ($urandom_range(0, 5) == 0);

            a  = m_pick(forwardA, id_ex_rs1_data, e_res, mem_wb_fwd_data);
            fb = m_pick(forwardB, id_ex_rs2_data, e_res, mem_wb_fwd_data);
            b  = id_ex_alu_src ? id_ex_imm : fb;
            #1;
            chk("rnd busy", {63'd0, ex_busy}, 64'd0);
            if (flush) begin
                e_valid = 0; e_rw = 0; e_mr = 0; e_mw = 0; e_m2r = 0; e_tk = 0;
                e_res = 0; e_st = 0; e_tgt = 0; e_rd = 0; e_known = 1;
            end else if (!mem_stall) begin
                e_valid = id_ex_valid;
                e_rw  = id_ex_valid & id_ex_reg_write;
                e_mr  = id_ex_valid & id_ex_mem_read;
                e_mw  = id_ex_valid & id_ex_mem_write;
                e_m2r = id_ex_valid & id_ex_mem_to_reg;
                e_tk  = id_ex_valid & id_ex_branch & m_br(id_ex_funct3, a, fb);
                e_res = m_alu(id_ex_alu_op, a, b);
                e_st  = fb;
                e_tgt = id_ex_pc + id_ex_imm;
                e_rd  = id_ex_rd;
                e_known = id_ex_valid;
            end
            tick();
            chk("rnd ctl", {58'd0, ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read,
                            ex_mem_mem_write, ex_mem_mem_to_reg, ex_mem_branch_taken},
                {58'd0, e_valid, e_rw, e_mr, e_mw, e_m2r, e_tk});
            if (e_known) begin
                chk("rnd result", {32'd0, ex_mem_alu_result}, {32'd0, e_res});
                chk("rnd store", {32'd0, ex_mem_store_data}, {32'd0, e_st});
                chk("rnd target", {32'd0, ex_mem_branch_target}, {32'd0, e_tgt});
                chk("rnd rd", {59'd0, ex_mem_rd}, {59'd0, e_rd});
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
